// File: rtl/dpram_pkg.sv
// Shared types and constants for the byte-enable dual-port RAM and its init sequencer.
package dpram_pkg;

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    localparam int unsigned RDW_OLD = 0;
    localparam int unsigned RDW_NEW = 1;

    function automatic int unsigned lane_count(input int unsigned data_width,
                                               input int unsigned byte_width);
        return data_width / byte_width;
    endfunction

endpackage

// File: rtl/dpram_init_seq.sv
// Post-reset clear sequencer: walks every address writing zero, then opens the RAM for use.
module dpram_init_seq
    import dpram_pkg::*;
#(
    parameter int unsigned ADDRESS_SIZE  = 3,
    parameter int unsigned ADDRESS_DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req,
    output logic                    busy,
    output logic                    req_drop,
    output logic                    clr_en,
    output logic [ADDRESS_SIZE-1:0] clr_addr
);

    state_t                  state_q, state_d;
    logic [ADDRESS_SIZE-1:0] clr_cnt_q, clr_cnt_d;
    logic                    busy_q, busy_d;
    logic                    req_drop_q, req_drop_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_CLEAR;
            clr_cnt_q  <= '0;
            busy_q     <= 1'b1;
            req_drop_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            busy_q     <= busy_d;
            req_drop_q <= req_drop_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        busy_d     = busy_q;
        clr_en     = 1'b0;
        req_drop_d = req & busy_q;
        unique case (state_q)
            ST_CLEAR: begin
                // Memory must stay untouched on reset edges.
                clr_en    = ~rst;
                clr_cnt_d = clr_cnt_q + ADDRESS_SIZE'(1);
                if (clr_cnt_q == ADDRESS_SIZE'(ADDRESS_DEPTH - 1)) begin
                    state_d = ST_READY;
                    busy_d  = 1'b0;
                end
            end
            ST_READY: begin
                busy_d = 1'b0;
            end
            default: begin
                state_d = ST_CLEAR;
                busy_d  = 1'b1;
            end
        endcase
    end

    assign busy     = busy_q;
    assign req_drop = req_drop_q;
    assign clr_addr = clr_cnt_q;

endmodule

// File: rtl/dual_port_ram_be.sv
// Simple dual-port RAM with byte-enable writes, 1/2-cycle read latency and defined collisions.
module dual_port_ram_be
    import dpram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned BYTE_WIDTH    = 8,
    parameter int unsigned ADDRESS_SIZE  = 3,
    parameter int unsigned ADDRESS_DEPTH = 8,
    parameter int unsigned RD_LATENCY    = 1,
    parameter int unsigned RDW_MODE      = 0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [DATA_WIDTH-1:0]              wr_data,
    input  logic                               we,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   wr_be,
    input  logic [ADDRESS_SIZE-1:0]            wr_addr,
    input  logic                               re,
    input  logic [ADDRESS_SIZE-1:0]            rd_addr,
    output logic [DATA_WIDTH-1:0]              rd_data,
    output logic                               rd_valid,
    output logic                               busy,
    output logic                               req_drop
);

    localparam int unsigned NumLanes = lane_count(DATA_WIDTH, BYTE_WIDTH);

    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_byte_width
        $error("DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if (ADDRESS_DEPTH != (1 << ADDRESS_SIZE)) begin : g_bad_depth
        $error("ADDRESS_DEPTH must equal 2**ADDRESS_SIZE");
    end
    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
        $error("RD_LATENCY must be 1 or 2");
    end

    logic [DATA_WIDTH-1:0]   mem [ADDRESS_DEPTH];
    logic                    clr_en;
    logic [ADDRESS_SIZE-1:0] clr_addr;
    logic                    wr_acc, rd_acc;
    logic [DATA_WIDTH-1:0]   wr_merged, rd_word;
    logic [DATA_WIDTH-1:0]   s1_data_q;
    logic                    s1_valid_q;

    dpram_init_seq #(
        .ADDRESS_SIZE  (ADDRESS_SIZE),
        .ADDRESS_DEPTH (ADDRESS_DEPTH)
    ) u_init_seq (
        .clk      (clk),
        .rst      (rst),
        .req      (we | re),
        .busy     (busy),
        .req_drop (req_drop),
        .clr_en   (clr_en),
        .clr_addr (clr_addr)
    );

    assign wr_acc = we & ~busy & ~rst;
    assign rd_acc = re & ~busy & ~rst;

    always_comb begin
        wr_merged = mem[wr_addr];
        for (int unsigned i = 0; i < NumLanes; i++) begin
            if (wr_be[i]) begin
                wr_merged[i*BYTE_WIDTH +: BYTE_WIDTH] = wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // New-data mode forwards the merged write word; old-data mode reads the array as-is.
    always_comb begin
        rd_word = mem[rd_addr];
        if (RDW_MODE == RDW_NEW && wr_acc && wr_addr == rd_addr) begin
            rd_word = wr_merged;
        end
    end

    always_ff @(posedge clk) begin
        if (clr_en) begin
            mem[clr_addr] <= '0;
        end else if (wr_acc) begin
            mem[wr_addr] <= wr_merged;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_data_q  <= '0;
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= rd_acc;
            if (rd_acc) begin
                s1_data_q <= rd_word;
            end
        end
    end

    if (RD_LATENCY == 1) begin : g_lat1
        assign rd_data  = s1_data_q;
        assign rd_valid = s1_valid_q;
    end else begin : g_lat2
        logic [DATA_WIDTH-1:0] s2_data_q;
        logic                  s2_valid_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                s2_data_q  <= '0;
                s2_valid_q <= 1'b0;
            end else begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_data_q <= s1_data_q;
                end
            end
        end

        assign rd_data  = s2_data_q;
        assign rd_valid = s2_valid_q;
    end

endmodule
